// File: rtl/ss_pkg.sv
// Shared definitions for the ss_shift_engine block: mode codes, FSM states
// and the lane fill-bit selector.
package ss_pkg;

  localparam logic [1:0] SS_SISO   = 2'b00;
  localparam logic [1:0] SS_SIPO   = 2'b01;
  localparam logic [1:0] SS_PISO   = 2'b10;
  localparam logic [1:0] SS_ROTATE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    FILL_SER,
    FILL_ZERO,
    FILL_ROT
  } fill_sel_t;

endpackage

// File: rtl/ss_shift_engine_if.sv
// Bus bundle of ss_shift_engine: control, serial lanes, both parallel
// handshakes, status and the FSM state for observation.
interface ss_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  localparam int CW = $clog2(WIDTH);

  logic                   en;
  logic [1:0]             mode;
  logic                   dir;
  logic [LANES-1:0]       ser_in;
  logic [LANES-1:0]       ser_out;
  logic [LANES*WIDTH-1:0] par_in;
  logic                   par_in_valid;
  logic                   par_in_ready;
  logic [LANES*WIDTH-1:0] par_out;
  logic                   par_out_valid;
  logic                   par_out_ready;
  logic                   busy;
  logic [CW-1:0]          bit_cnt;
  ss_pkg::state_t         state;

  modport master (
    output en, mode, dir, ser_in, par_in, par_in_valid, par_out_ready,
    input  ser_out, par_in_ready, par_out, par_out_valid, busy, bit_cnt, state
  );

  modport slave (
    input  en, mode, dir, ser_in, par_in, par_in_valid, par_out_ready,
    output ser_out, par_in_ready, par_out, par_out_valid, busy, bit_cnt, state
  );

endinterface

// File: rtl/ss_lane.sv
// One WIDTH-bit shift lane: parallel load, shift in either direction, and a
// fill bit taken from the serial input, zero, or the outgoing bit.
module ss_lane
  import ss_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  fill_sel_t        fill_sel,
  input  logic             fill_in,
  input  logic [WIDTH-1:0] word_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             fill;

  always_comb begin
    ser_out = dir ? reg_q[0] : reg_q[WIDTH-1];
    case (fill_sel)
      FILL_SER: fill = fill_in;
      FILL_ROT: fill = ser_out;
      default:  fill = 1'b0;
    endcase
    reg_d = reg_q;
    if (load) begin
      reg_d = word_in;
    end else if (shift) begin
      reg_d = dir ? {fill, reg_q[WIDTH-1:1]} : {reg_q[WIDTH-2:0], fill};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) reg_q <= '0;
    else     reg_q <= reg_d;
  end

  assign q = reg_q;

endmodule

// File: rtl/ss_shift_engine.sv
// LANES parallel shift lanes under one FSM: SISO delay line, SIPO deserialiser,
// PISO serialiser; mode 11 is a circular ROTATE only when SS_ROTATE_EN is defined.
module ss_shift_engine
  import ss_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  ss_shift_engine_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            dir_q, dir_d;
  logic            pov_q, pov_d;
  logic [1:0]      mode_n;
  logic            eff_dir;
  logic            shift, load, pir;
  fill_sel_t       fill_sel;
  logic [LANES*WIDTH-1:0] lane_q;
  logic [LANES-1:0]       lane_so;

  always_comb begin
    mode_n = bus.mode;
`ifndef SS_ROTATE_EN
    if (bus.mode == SS_ROTATE) mode_n = SS_SISO;
`endif
  end

  // Mode/dir inputs act directly while idle; once busy the latched copies rule.
  assign eff_dir = (state_q == IDLE) ? bus.dir : dir_q;

  // Handshakes: a word moves on a rising edge where valid & ready are both high
  // and en=1; valid never waits on ready, ready is zero whenever en=0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    pov_d    = pov_q;
    shift    = 1'b0;
    load     = 1'b0;
    pir      = 1'b0;
    fill_sel = FILL_SER;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          mode_d = mode_n;
          dir_d  = bus.dir;
          case (mode_n)
            SS_SIPO: begin
              state_d = SHIFT;
              cnt_d   = '0;
            end
`ifdef SS_ROTATE_EN
            SS_PISO, SS_ROTATE: begin
`else
            SS_PISO: begin
`endif
              pir = 1'b1;
              if (bus.par_in_valid) begin
                load    = 1'b1;
                state_d = SHIFT;
                cnt_d   = '0;
              end
            end
            default: shift = 1'b1;
          endcase
        end
        SHIFT: begin
          shift = 1'b1;
          case (mode_q)
            SS_PISO: fill_sel = FILL_ZERO;
`ifdef SS_ROTATE_EN
            SS_ROTATE: fill_sel = FILL_ROT;
`endif
            default: fill_sel = FILL_SER;
          endcase
          if (cnt_q == LAST) begin
            cnt_d = '0;
            case (mode_q)
              SS_SIPO: begin
                state_d = HOLD;
                pov_d   = 1'b1;
              end
              SS_PISO: begin
                pir = 1'b1;
                if (bus.par_in_valid) load = 1'b1;
                else                  state_d = IDLE;
              end
`ifdef SS_ROTATE_EN
              SS_ROTATE: if (bus.mode != SS_ROTATE) state_d = IDLE;
`endif
              default: state_d = IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (bus.par_out_ready) begin
            pov_d   = 1'b0;
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= SS_SISO;
      dir_q   <= 1'b0;
      pov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pov_q   <= pov_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ss_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift    (shift),
      .dir      (eff_dir),
      .fill_sel (fill_sel),
      .fill_in  (bus.ser_in[k]),
      .word_in  (bus.par_in[k*WIDTH +: WIDTH]),
      .q        (lane_q[k*WIDTH +: WIDTH]),
      .ser_out  (lane_so[k])
    );
  end

  assign bus.par_out       = lane_q;
  assign bus.ser_out       = lane_so;
  assign bus.par_in_ready  = pir;
  assign bus.par_out_valid = pov_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.bit_cnt       = cnt_q;
  assign bus.state         = state_q;

endmodule
